reset_sequencer: RTL and testbench

Parametrised power-on and system reset sequencer: it synchronises an asynchronous active-low board reset and holds a programmable number of downstream reset domains in reset for a minimum time. It then releases those domains one at a time, in a fixed order, with a programmable gap between releases. It sits at the top level between the board reset/PLL-lock source and every clocked subsystem, and replaces fixed-count single-output reset generation.

---
 rtl/reset_seq_pkg.sv | 26 ++
 rtl/reset_sync.sv | 30 +++
 rtl/reset_sequencer.sv | 144 ++++++++++++++
 tb/tb_reset_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// ============================================================================
//  Module   : reset_seq_pkg
//  Brief    : Shared state encoding and counter sizing for reset_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        DONE      = 2'd3
    } seq_state_t;

    // Wide enough to hold the largest terminal count itself, so 2**n is reachable.
    function automatic int cnt_width(input int hold, input int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/reset_sync.sv
// ============================================================================
//  Module   : reset_sync
//  Brief    : Async-assert / sync-deassert chain producing an active-high run.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    output logic run
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign run = r_chain[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ============================================================================
//  Module   : reset_sequencer
//  Brief    : Holds NUM_STAGES reset domains, then releases them in order.
//             Optional soft restart input enabled by RESET_SEQ_SOFT_REQ_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYCLES = 15,
    parameter int STAGE_GAP   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
`ifdef RESET_SEQ_SOFT_REQ_EN
    input  logic                  soft_req,
`endif
    output logic [NUM_STAGES-1:0] stage_reset,
    output logic                  done
);

    localparam int c_cnt_w = cnt_width(HOLD_CYCLES, STAGE_GAP);
    localparam int c_idx_w = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [NUM_STAGES-1:0] c_one = NUM_STAGES'(1);

    if (NUM_STAGES < 1) begin : g_bad_num_stages
        $error("reset_sequencer: NUM_STAGES must be >= 1");
    end
    if (STAGE_GAP < 1) begin : g_bad_stage_gap
        $error("reset_sequencer: STAGE_GAP must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("reset_sequencer: SYNC_STAGES must be >= 2");
    end

    logic                  w_run;
    seq_state_t            r_state, w_state;
    logic [c_cnt_w-1:0]    r_cnt,   w_cnt;
    logic [c_idx_w-1:0]    r_idx,   w_idx;
    logic [NUM_STAGES-1:0] r_stage, w_stage;
    logic                  r_done,  w_done;

    reset_sync #(.SYNC_STAGES(SYNC_STAGES)) u_reset_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (w_run)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= WAIT_SYNC;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_stage <= '1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_stage <= w_stage;
            r_done  <= w_done;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_stage = r_stage;
        w_done  = r_done;

        case (r_state)
            WAIT_SYNC: begin
                w_stage = '1;
                w_done  = 1'b0;
                if (w_run) begin
                    w_state = HOLD;
                    w_cnt   = '0;
                end
            end
            HOLD: begin
                if (r_cnt == c_cnt_w'(HOLD_CYCLES)) begin
                    w_stage = r_stage & ~c_one;
                    w_cnt   = '0;
                    if (NUM_STAGES == 1) begin
                        w_state = DONE;
                        w_done  = 1'b1;
                    end else begin
                        w_state = RELEASE;
                        w_idx   = c_idx_w'(1);
                    end
                end else begin
                    w_cnt = r_cnt + c_cnt_w'(1);
                end
            end
            RELEASE: begin
                if (r_cnt == c_cnt_w'(STAGE_GAP - 1)) begin
                    w_stage = r_stage & ~(c_one << r_idx);
                    w_cnt   = '0;
                    if (r_idx == c_idx_w'(NUM_STAGES - 1)) begin
                        w_state = DONE;
                        w_done  = 1'b1;
                    end else begin
                        w_idx = r_idx + c_idx_w'(1);
                    end
                end else begin
                    w_cnt = r_cnt + c_cnt_w'(1);
                end
            end
            DONE: begin
                w_stage = '0;
                w_done  = 1'b1;
            end
            default: begin
                w_state = WAIT_SYNC;
                w_cnt   = '0;
                w_idx   = '0;
                w_stage = '1;
                w_done  = 1'b0;
            end
        endcase

`ifdef RESET_SEQ_SOFT_REQ_EN
        // A soft request overrides whatever the state did this cycle and restarts HOLD.
        if (soft_req && (r_state != WAIT_SYNC)) begin
            w_state = HOLD;
            w_cnt   = '0;
            w_idx   = '0;
            w_stage = '1;
            w_done  = 1'b0;
        end
`endif
    end

    assign stage_reset = r_stage;
    assign done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
//  Module   : tb_reset_sequencer
//  Brief    : Directed checks of release timing, glitch restart and soft restart.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reset_sequencer;

    logic       clk;
    logic       reset_n;
    logic       soft_req;
    logic [2:0] sr_a;
    logic       done_a;
    logic [3:0] sr_b;
    logic       done_b;
    logic [0:0] sr_c;
    logic       done_c;

    int n_tests;
    int n_fail;
    int edge_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    reset_sequencer u_dut_a (
        .clk         (clk),
        .reset_n     (reset_n),
`ifdef RESET_SEQ_SOFT_REQ_EN
        .soft_req    (soft_req),
`endif
        .stage_reset (sr_a),
        .done        (done_a)
    );

    reset_sequencer #(.NUM_STAGES(4), .HOLD_CYCLES(16), .STAGE_GAP(1)) u_dut_b (
        .clk         (clk),
        .reset_n     (reset_n),
`ifdef RESET_SEQ_SOFT_REQ_EN
        .soft_req    (1'b0),
`endif
        .stage_reset (sr_b),
        .done        (done_b)
    );

    reset_sequencer #(.NUM_STAGES(1), .HOLD_CYCLES(0)) u_dut_c (
        .clk         (clk),
        .reset_n     (reset_n),
`ifdef RESET_SEQ_SOFT_REQ_EN
        .soft_req    (1'b0),
`endif
        .stage_reset (sr_c),
        .done        (done_c)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // Default config: bit i falls on edge base+4*i, done with the last bit.
    function automatic logic [2:0] exp3(input int e, input int base);
        logic [2:0] v;
        for (int i = 0; i < 3; i++) v[i] = (e < base + 4 * i);
        return v;
    endfunction

    function automatic logic [3:0] exp4(input int e);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (e < 20 + i);
        return v;
    endfunction

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        edge_n   = 0;
        reset_n  = 1'b0;
        soft_req = 1'b0;

        // Power-on: held in reset for 3 cycles
        repeat (3) tick();
        chk("rst_sr_a",   32'(sr_a),   32'h7);
        chk("rst_done_a", 32'(done_a), 32'h0);
        chk("rst_sr_b",   32'(sr_b),   32'hF);
        chk("rst_sr_c",   32'(sr_c),   32'h1);
        chk("rst_done_c", 32'(done_c), 32'h0);

        reset_n = 1'b1;
        edge_n  = 0;
        for (int e = 1; e <= 30; e++) begin
            tick();
            chk("def_sr",    32'(sr_a),   32'(exp3(e, 19)));
            chk("def_done",  32'(done_a), 32'(e >= 27));
            chk("wide_sr",   32'(sr_b),   32'(exp4(e)));
            chk("wide_done", 32'(done_b), 32'(e >= 23));
            chk("one_sr",    32'(sr_c),   32'(e < 4));
            chk("one_done",  32'(done_c), 32'(e >= 4));
        end

        // Second run, interrupted mid-release by a half-cycle reset glitch
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        edge_n  = 0;
        for (int e = 1; e <= 21; e++) begin
            tick();
            chk("run2_sr", 32'(sr_a), 32'(exp3(e, 19)));
        end
        #2 reset_n = 1'b0;
        #1;
        chk("glitch_sr",   32'(sr_a),   32'h7);
        chk("glitch_done", 32'(done_a), 32'h0);
        chk("glitch_sr_b", 32'(sr_b),   32'hF);
        #4 reset_n = 1'b1;
        edge_n = 0;
        for (int e = 1; e <= 39; e++) begin
            tick();
            chk("restart_sr",   32'(sr_a),   32'(exp3(e, 19)));
            chk("restart_done", 32'(done_a), 32'(e >= 27));
        end

`ifdef RESET_SEQ_SOFT_REQ_EN
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        chk("soft1_sr",   32'(sr_a),   32'h7);
        chk("soft1_done", 32'(done_a), 32'h0);
        for (int e = 41; e <= 57; e++) begin
            tick();
            chk("soft1_seq", 32'(sr_a), 32'(exp3(e, 56)));
        end
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        chk("soft2_sr", 32'(sr_a), 32'h7);
        for (int e = 59; e <= 90; e++) begin
            tick();
            chk("soft2_seq",  32'(sr_a),   32'(exp3(e, 74)));
            chk("soft2_done", 32'(done_a), 32'(e >= 82));
        end
`endif

        // DONE is stable for a long idle stretch
        for (int k = 0; k < 1000; k++) begin
            tick();
            chk("hold_sr",   32'(sr_a),   32'h0);
            chk("hold_done", 32'(done_a), 32'h1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
